// File: rtl/root_arbiter_if.sv
// root_arbiter_if: bundles the requester-side and engine-side signals of the
// root-computation arbiter.
//
// Handshake rules (all channels):
//   - Request: requester i drives req_valid[i] with req_data_1/req_data_2 slice i
//     and holds them until a transfer. A transfer happens on a rising edge where
//     req_valid[i] && req_ready[i]. req_ready is one-hot or zero.
//   - Response: rsp_valid is a one-hot, single-cycle strobe with no back-pressure.
//     rsp_data/rsp_err qualify it and rsp_data is 0 when no strobe is high.
//   - Engine: eng_in_valid is a single-cycle start pulse. eng_in_data_* hold their
//     value until the next accept. eng_out_valid is a single-cycle completion
//     strobe, and it only counts while the arbiter is waiting.
//
// Modports:
//   slave  - the arbiter side (root_arbiter)
//   master - the requester/engine environment side
interface root_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*10-1:0] req_data_1;
  logic [NREQ*3-1:0]  req_data_2;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [19:0]        rsp_data;
  logic               rsp_err;
  logic               eng_in_valid;
  logic [9:0]         eng_in_data_1;
  logic [2:0]         eng_in_data_2;
  logic               eng_out_valid;
  logic [19:0]        eng_out_data;

  modport slave (
    input  req_valid, req_data_1, req_data_2, eng_out_valid, eng_out_data,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           eng_in_valid, eng_in_data_1, eng_in_data_2
  );

  modport master (
    output req_valid, req_data_1, req_data_2, eng_out_valid, eng_out_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           eng_in_valid, eng_in_data_1, eng_in_data_2
  );
endinterface

// File: rtl/root_arbiter.sv
// root_arbiter: round-robin arbiter and sequencer that shares one root engine
// between NREQ requesters. It accepts one (radicand, exponent) pair at a time,
// starts the engine with a one-cycle pulse, and holds the operands stable. It
// then routes the 20-bit result, or an error, back to the requester that issued
// the request.
//
// Ports:
//   clk, rst   - clock, and asynchronous active-high reset
//   bus        - root_arbiter_if.slave (requester handshake + engine port)
//   busy       - high in every state except IDLE
//   fault      - sticky, set when the engine fails to answer within TIMEOUT
//   state_dbg  - current FSM state encoding (IDLE=0 LAUNCH=1 WAIT=2 RESP=3 FAULT=4)
module root_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  root_arbiter_if.slave bus,
  output logic          busy,
  output logic          fault,
  output logic [2:0]    state_dbg
);

  localparam int          IW = $clog2(NREQ);
  localparam logic [9:0]  TO = 10'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [9:0]    d1_q, d1_d;
  logic [2:0]    d2_q, d2_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [19:0]   res_q, res_d;
  logic          err_q, err_d;
  logic          fault_q, fault_d;

  // Round-robin pick: the first valid requester at or after last_grant+1.
  logic [NREQ-1:0] gnt_vec;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;
  logic            gnt_found;
  logic [9:0]      sel_d1;
  logic [2:0]      sel_d2;

  always_comb begin : arb
    gnt_vec   = '0;
    gnt_idx   = '0;
    cand      = '0;
    gnt_found = 1'b0;
    sel_d1    = '0;
    sel_d2    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(last_grant_q) + 1 + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_found && gnt_idx == IW'(k)) begin
        gnt_vec[k] = 1'b1;
        sel_d1     = bus.req_data_1[k*10 +: 10];
        sel_d2     = bus.req_data_2[k*3 +: 3];
      end
    end
  end

  always_comb begin : fsm
    state_d      = state_q;
    idx_d        = idx_q;
    last_grant_d = last_grant_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    err_d        = err_q;
    fault_d      = fault_q;
    case (state_q)
      S_IDLE: begin
        // A grant is only ever given to a valid requester, so a grant is a transfer.
        if (gnt_found) begin
          idx_d        = gnt_idx;
          last_grant_d = gnt_idx;
          d1_d         = sel_d1;
          d2_d         = sel_d2;
          if (sel_d2 == 3'd0) begin
            // The zeroth root is undefined. Answer with an error and leave the engine untouched.
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_out_valid) begin
          res_d   = bus.eng_out_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TO) begin
          res_d   = '0;
          err_d   = 1'b1;
          fault_d = 1'b1;
          state_d = S_RESP;
        end else begin
          // The counter only steps below TO, so it saturates there.
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_RESP: begin
        state_d = fault_q ? S_FAULT : S_IDLE;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      last_grant_q <= IW'(NREQ - 1);
      d1_q         <= '0;
      d2_q         <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_grant_q <= last_grant_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      err_q        <= err_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin : outs
    // Gate on rst so req_ready is already 0 while reset is held and requesters are valid.
    bus.req_ready     = (state_q == S_IDLE && !rst) ? gnt_vec : '0;
    bus.eng_in_valid  = (state_q == S_LAUNCH);
    bus.eng_in_data_1 = d1_q;
    bus.eng_in_data_2 = d2_q;
    bus.rsp_data      = (state_q == S_RESP) ? res_q : '0;
    bus.rsp_err       = (state_q == S_RESP) && err_q;
    bus.rsp_valid     = '0;
    for (int k = 0; k < NREQ; k++) begin
      bus.rsp_valid[k] = (state_q == S_RESP) && (idx_q == IW'(k));
    end
    busy      = (state_q != S_IDLE);
    fault     = fault_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_root_arbiter.sv
module tb_root_arbiter;
  localparam int NREQ = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_t = 1'b1;
  always #5 clk = ~clk;

  logic       busy, fault, busy_t, fault_t;
  logic [2:0] st, st_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [NREQ-1:0] exp_q[$];

  root_arbiter_if #(.NREQ(NREQ)) bus ();
  root_arbiter_if #(.NREQ(NREQ)) bus_t ();

  root_arbiter #(.NREQ(NREQ), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .fault(fault), .state_dbg(st)
  );
  root_arbiter #(.NREQ(NREQ), .TIMEOUT(15)) dut_t (
    .clk(clk), .rst(rst_t), .bus(bus_t), .busy(busy_t), .fault(fault_t), .state_dbg(st_t)
  );

  typedef struct {
    int              r;
    logic [9:0]      d1;
    logic [2:0]      d2;
    int              lat;
    logic [19:0]     eng_res;
    logic [NREQ-1:0] exp_rsp;
    logic [19:0]     exp_data;
    logic            exp_err;
  } vec_t;
  vec_t vecs[5];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [9:0] d1, input logic [2:0] d2);
    bus.req_valid[r]         = 1'b1;
    bus.req_data_1[r*10 +: 10] = d1;
    bus.req_data_2[r*3 +: 3]   = d2;
  endtask

  task automatic wait_grant(input int r, input string name);
    int n = 0;
    #1;
    while (!bus.req_ready[r] && n < 20) begin
      tick();
      #1;
      n++;
    end
    check(name, 32'(bus.req_ready), 32'(1 << r));
  endtask

  // Called at the LAUNCH cycle. Returns at the cycle after eng_out_valid.
  task automatic serve_engine(input int lat, input logic [19:0] res,
                              input logic [9:0] e1, input logic [2:0] e2);
    int bad = 0;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (bus.eng_in_valid || bus.eng_in_data_1 !== e1 || bus.eng_in_data_2 !== e2 ||
          bus.rsp_valid !== '0 || !busy) bad++;
    end
    check("operand_hold", 32'(bad), 32'd0);
    bus.eng_out_valid = 1'b1;
    bus.eng_out_data  = res;
    tick();
    bus.eng_out_valid = 1'b0;
    bus.eng_out_data  = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    set_req(v.r, v.d1, v.d2);
    wait_grant(v.r, "vec_grant");
    tick();
    bus.req_valid[v.r] = 1'b0;
    if (v.d2 != 3'd0) begin
      check("vec_launch", 32'(bus.eng_in_valid), 32'd1);
      check("vec_eng_d1", 32'(bus.eng_in_data_1), 32'(v.d1));
      check("vec_eng_d2", 32'(bus.eng_in_data_2), 32'(v.d2));
      serve_engine(v.lat, v.eng_res, v.d1, v.d2);
    end else begin
      check("exp0_no_launch", 32'(bus.eng_in_valid), 32'd0);
    end
    check("vec_rsp_valid", 32'(bus.rsp_valid), 32'(v.exp_rsp));
    check("vec_rsp_data", 32'(bus.rsp_data), 32'(v.exp_data));
    check("vec_rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    tick();
    check("vec_idle", 32'({busy, bus.eng_in_valid, bus.rsp_valid}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{2, 10'd27,   3'd3, 40, 20'h00060, 4'b0100, 20'h00060, 1'b0};
    vecs[1] = '{3, 10'd100,  3'd0, 0,  20'hFFFFF, 4'b1000, 20'h00000, 1'b1};
    vecs[2] = '{0, 10'd1023, 3'd7, 1,  20'hFFFFF, 4'b0001, 20'hFFFFF, 1'b0};
    vecs[3] = '{1, 10'd0,    3'd1, 5,  20'h00000, 4'b0010, 20'h00000, 1'b0};
    vecs[4] = '{2, 10'd512,  3'd4, 10, 20'h12345, 4'b0100, 20'h12345, 1'b0};

    bus.req_valid = '0; bus.req_data_1 = '0; bus.req_data_2 = '0;
    bus.eng_out_valid = 1'b0; bus.eng_out_data = '0;
    bus_t.req_valid = '0; bus_t.req_data_1 = '0; bus_t.req_data_2 = '0;
    bus_t.eng_out_valid = 1'b0; bus_t.eng_out_data = '0;

    // Reset values.
    @(negedge clk);
    check("rst_outputs", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.eng_in_valid, busy, fault}), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_eng_data", 32'({bus.eng_in_data_1, bus.eng_in_data_2}), 32'd0);
    rst = 1'b0;
    tick();

    // Round-robin: all four requesters valid continuously.
    for (int i = 0; i < NREQ; i++) set_req(i, 10'(10 * i + 5), 3'(i + 1));
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    for (int g = 0; g < 5; g++) begin
      logic [NREQ-1:0] e;
      int k;
      e = exp_q.pop_front();
      k = g % NREQ;
      #1;
      check("rr_grant", 32'(bus.req_ready), 32'(e));
      tick();
      check("rr_eng_d1", 32'(bus.eng_in_data_1), 32'(10 * k + 5));
      serve_engine(2 + g, 20'(1000 + g), 10'(10 * k + 5), 3'(k + 1));
      check("rr_rsp_valid", 32'(bus.rsp_valid), 32'(e));
      check("rr_rsp_data", 32'(bus.rsp_data), 32'(1000 + g));
      tick();
    end
    bus.req_valid = '0;
    tick();

    // Table-driven single requests.
    for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

    // eng_out_valid outside WAIT is ignored.
    bus.eng_out_valid = 1'b1; bus.eng_out_data = 20'hABCDE;
    tick(); tick();
    bus.eng_out_valid = 1'b0; bus.eng_out_data = '0;
    check("stray_done", 32'({busy, bus.rsp_valid, bus.rsp_err}), 32'd0);
    tick();
    check("stray_done_after", 32'({busy, bus.rsp_valid, bus.rsp_data}), 32'd0);

    // Operand hold: requester 1 changes its pending data while the engine runs.
    set_req(1, 10'd200, 3'd5);
    wait_grant(1, "hold_grant");
    tick();
    check("hold_launch", 32'({bus.eng_in_valid, bus.eng_in_data_1, bus.eng_in_data_2}),
          32'({1'b1, 10'd200, 3'd5}));
    set_req(1, 10'd300, 3'd6);
    serve_engine(12, 20'h0ABCD, 10'd200, 3'd5);
    check("hold_rsp", 32'({bus.rsp_valid, bus.rsp_data}), 32'({4'b0010, 20'h0ABCD}));
    check("hold_no_ready_in_resp", 32'(bus.req_ready), 32'd0);
    tick();
    #1;
    check("hold_ready_w2", 32'(bus.req_ready), 32'b0010);
    check("hold_d1_until_accept", 32'(bus.eng_in_data_1), 32'd200);
    tick();
    bus.req_valid[1] = 1'b0;
    check("hold_second_launch", 32'({bus.eng_in_valid, bus.eng_in_data_1, bus.eng_in_data_2}),
          32'({1'b1, 10'd300, 3'd6}));
    serve_engine(3, 20'h00042, 10'd300, 3'd6);
    check("hold_second_rsp", 32'({bus.rsp_valid, bus.rsp_data}), 32'({4'b0010, 20'h00042}));
    tick();

    // Reset mid-WAIT.
    set_req(0, 10'd77, 3'd2);
    wait_grant(0, "rstw_grant");
    tick();
    check("rstw_launch", 32'(bus.eng_in_valid), 32'd1);
    set_req(0, 10'd11, 3'd1);
    set_req(2, 10'd22, 3'd3);
    for (int i = 0; i < 5; i++) tick();
    check("rstw_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_outputs", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.eng_in_valid, busy, fault}), 32'd0);
    check("rstw_data", 32'({bus.eng_in_data_1, bus.eng_in_data_2, bus.rsp_data}), 32'd0);
    tick();
    check("rstw_held", 32'({bus.req_ready, bus.rsp_valid, bus.eng_in_valid}), 32'd0);
    rst = 1'b0;
    #1;
    check("rstw_first_grant", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid[0] = 1'b0;
    check("rstw_relaunch", 32'({bus.eng_in_valid, bus.eng_in_data_1}), 32'({1'b1, 10'd11}));
    serve_engine(2, 20'h00777, 10'd11, 3'd1);
    check("rstw_rsp", 32'({bus.rsp_valid, bus.rsp_data}), 32'({4'b0001, 20'h00777}));
    bus.req_valid[2] = 1'b0;
    tick();

    // Timeout on the TIMEOUT=15 instance: the engine never answers.
    rst_t = 1'b0;
    tick();
    bus_t.req_valid[1] = 1'b1;
    bus_t.req_data_1[19:10] = 10'd50;
    bus_t.req_data_2[5:3] = 3'd2;
    #1;
    check("to_grant", 32'(bus_t.req_ready), 32'b0010);
    tick();
    bus_t.req_valid[1] = 1'b0;
    check("to_launch", 32'(bus_t.eng_in_valid), 32'd1);
    begin
      int bad = 0;
      for (int i = 1; i <= 16; i++) begin
        tick();
        if (bus_t.rsp_valid !== '0 || bus_t.eng_in_valid || !busy_t || fault_t) bad++;
      end
      check("to_wait_quiet", 32'(bad), 32'd0);
    end
    tick();
    check("to_rsp", 32'({bus_t.rsp_valid, bus_t.rsp_err, bus_t.rsp_data}),
          32'({4'b0010, 1'b1, 20'h0}));
    check("to_fault_set", 32'(fault_t), 32'd1);
    tick();
    bus_t.req_valid = '1;
    #1;
    check("to_fault_state", 32'({bus_t.req_ready, busy_t, fault_t, bus_t.rsp_valid}),
          32'({4'b0000, 1'b1, 1'b1, 4'b0000}));
    for (int i = 0; i < 4; i++) tick();
    check("to_fault_sticky", 32'({bus_t.req_ready, busy_t, fault_t}), 32'({4'b0000, 1'b1, 1'b1}));
    rst_t = 1'b1;
    #1;
    check("to_rst_clears", 32'({bus_t.req_ready, busy_t, fault_t, bus_t.rsp_valid}), 32'd0);
    bus_t.req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end
endmodule
